// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch: one outstanding AXI4-Lite read, a single-entry buffer toward decode,
// static backward-branch-taken prediction and flush/jump redirect of the PC.
module ysyx_23060203_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_dnpc,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);
    typedef enum logic [1:0] {StReq, StResp, StOut} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        arvalid_q, arvalid_d;
    logic        discard_q, discard_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] imm_b;
    logic [31:0] npc;
    logic        ar_fire;

    assign redirect = flush | jump_flush;
    assign target   = {(flush ? flush_dnpc[31:1] : jump_dnpc[31:1]), 1'b0};
    assign imm_b    = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign npc      = ((inst_q[6:2] == 5'b11000) && inst_q[31]) ? pc_q + imm_b : pc_q + 32'd4;
    assign ar_fire  = arvalid_q & arready;

    assign araddr    = pc_q;
    assign arvalid   = arvalid_q;
    assign rready    = (state_q == StResp);
    // Suppressed combinationally so decode can never take a wrong-path word in a redirect cycle.
    assign out_valid = (state_q == StOut) & ~redirect;
    assign out_pc    = pc_q;
    assign out_inst  = inst_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        discard_d = discard_q;
        arvalid_d = 1'b0;
        unique case (state_q)
            StReq: begin
                arvalid_d = ~ar_fire;
                if (redirect) begin
                    pc_d = target;
                end
                if (ar_fire) begin
                    state_d   = StResp;
                    discard_d = redirect;
                end
            end
            StResp: begin
                if (redirect) begin
                    pc_d      = target;
                    discard_d = ~rvalid;
                    if (rvalid) begin
                        state_d = StReq;
                    end
                end else if (rvalid) begin
                    discard_d = 1'b0;
                    if (discard_q) begin
                        state_d = StReq;
                    end else begin
                        inst_d  = rdata;
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = StReq;
                end else if (out_ready) begin
                    pc_d    = npc;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            arvalid_q <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            arvalid_q <= arvalid_d;
            discard_q <= discard_d;
        end
    end

    rresp_okay: assert property (@(posedge clock) disable iff (reset)
        (rvalid & rready) |-> (rresp == 2'b00));

endmodule

// File: tb/tb_ysyx_23060203_ifu_fetch.sv
// Bench for ysyx_23060203_ifu_fetch: bench-side AXI-Lite memory, directed scenarios and a
// randomized run replayed against a PC-sequence reference model.
`timescale 1ns/1ps
module tb_ysyx_23060203_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam int EV_AR = 0;
    localparam int EV_OUT = 1;
    localparam int EV_REDIR = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush, jump_flush, out_ready, arready, rvalid;
    logic        arvalid, rready, out_valid;
    logic [31:0] flush_dnpc, jump_dnpc, araddr, rdata, out_pc, out_inst;
    logic [1:0]  rresp;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        bit          redir;
    } ev_t;
    ev_t evq[$];

    logic [31:0] mem_ovr [logic [31:0]];
    bit          mem_rand = 0;
    int          ar_pct = 100;
    int          r_delay = 0;
    bit          rand_ready = 0;
    bit          pending = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;

    always #5 clock = ~clock;

    ysyx_23060203_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .flush(flush), .flush_dnpc(flush_dnpc),
        .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    function automatic logic [31:0] mem(input logic [31:0] addr);
        logic [31:0] h;
        if (mem_ovr.exists(addr)) return mem_ovr[addr];
        if (!mem_rand) return 32'h0000_0013;
        h = (addr ^ 32'h5bd1_e995) * 32'h9e37_79b1;
        h = h ^ (h >> 15);
        if (h[2:0] == 3'd0) h[6:0] = 7'b110_0011;
        return h;
    endfunction

    // Reference next PC: taken only for B-type with a negative offset.
    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
        int off;
        if (inst[6:2] == 5'd24 && inst[31]) begin
            off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048 - 4096;
            return pc + 32'(off);
        end
        return pc + 32'd4;
    endfunction

    // One cycle: present slave outputs, log what fires at the coming edge, end on negedge.
    task automatic step();
        ev_t e;
        bit  redir_now;
        arready = (!pending && ($urandom_range(99) < ar_pct)) ? 1'b1 : 1'b0;
        rvalid  = (pending && pend_cnt == 0) ? 1'b1 : 1'b0;
        rdata   = pending ? mem(pend_addr) : 32'hdead_beef;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
        #1;
        redir_now = flush | jump_flush;
        if (reset) begin
            pending = 0;
        end else begin
            if (rvalid && rready) pending = 0;
            else if (pending && pend_cnt > 0) pend_cnt--;
            if (arvalid && arready) begin
                e = '{kind: EV_AR, a: araddr, b: 32'h0, redir: redir_now};
                evq.push_back(e);
                pending   = 1;
                pend_addr = araddr;
                pend_cnt  = (r_delay < 0) ? int'($urandom_range(3)) : r_delay;
            end
            if (out_valid && out_ready) begin
                e = '{kind: EV_OUT, a: out_pc, b: out_inst, redir: redir_now};
                evq.push_back(e);
            end
            if (redir_now) begin
                e = '{kind: EV_REDIR, a: flush ? flush_dnpc : jump_dnpc, b: 32'h0, redir: 1'b1};
                evq.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    function automatic int count_ev(input int kind);
        int k = 0;
        foreach (evq[i]) if (evq[i].kind == kind) k++;
        return k;
    endfunction

    function automatic bit find_ev(input int kind, input int nth,
                                   output logic [31:0] a, output logic [31:0] b);
        int k = 0;
        a = 32'hx;
        b = 32'hx;
        foreach (evq[i]) begin
            if (evq[i].kind == kind) begin
                if (k == nth) begin
                    a = evq[i].a;
                    b = evq[i].b;
                    return 1;
                end
                k++;
            end
        end
        return 0;
    endfunction

    task automatic run_until(input int kind, input int n, input int budget);
        for (int i = 0; i < budget && count_ev(kind) < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1; flush = 0; jump_flush = 0; out_ready = 1; rand_ready = 0;
        flush_dnpc = 32'h0; jump_dnpc = 32'h0;
        step();
        step();
        reset = 0;
        evq.delete();
    endtask

    task automatic test_reset();
        mem_ovr.delete(); mem_rand = 0; ar_pct = 0; r_delay = 0;
        reset = 1; flush = 0; jump_flush = 0; out_ready = 1; rresp = 2'b00;
        flush_dnpc = 32'h0; jump_dnpc = 32'h0;
        step();
        step();
        n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
        n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", rready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (araddr !== RESET_PC) begin n_fail++; $display("FAIL reset_araddr: got %h expected %h", araddr, RESET_PC); end
        reset = 0;
        n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL req_entry_arvalid: got %b expected 0", arvalid); end
        step();
        n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL req_arvalid_rise: got %b expected 1", arvalid); end
        step();
        n_checks++; if (arvalid !== 1'b1 || araddr !== RESET_PC) begin n_fail++; $display("FAIL req_hold: got %b/%h expected 1/%h", arvalid, araddr, RESET_PC); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] a, b;
        bit ok;
        ar_pct = 100; r_delay = 0;
        do_reset();
        run_until(EV_AR, 2, 40);
        ok = find_ev(EV_AR, 0, a, b);
        n_checks++; if (!ok || a !== RESET_PC) begin n_fail++; $display("FAIL basic_ar0: got %h expected %h", a, RESET_PC); end
        ok = find_ev(EV_OUT, 0, a, b);
        n_checks++; if (!ok || a !== RESET_PC || b !== 32'h13) begin n_fail++; $display("FAIL basic_out0: got %h/%h expected %h/00000013", a, b, RESET_PC); end
        ok = find_ev(EV_AR, 1, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0004) begin n_fail++; $display("FAIL basic_ar1: got %h expected 30000004", a); end
    endtask

    task automatic test_branch_predict();
        logic [31:0] a, b;
        bit ok;
        ar_pct = 100; r_delay = 0;
        mem_ovr[32'h3000_0010] = 32'hFE00_0EE3;
        do_reset();
        run_until(EV_AR, 7, 120);
        ok = find_ev(EV_OUT, 4, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0010 || b !== 32'hFE00_0EE3) begin n_fail++; $display("FAIL bwd_out: got %h/%h expected 30000010/fe000ee3", a, b); end
        ok = find_ev(EV_AR, 5, a, b);
        n_checks++; if (!ok || a !== 32'h3000_000C) begin n_fail++; $display("FAIL bwd_taken: got %h expected 3000000c", a); end
        ok = find_ev(EV_AR, 6, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0010) begin n_fail++; $display("FAIL bwd_loop: got %h expected 30000010", a); end
        mem_ovr[32'h3000_0010] = 32'h0000_0463;
        do_reset();
        run_until(EV_AR, 6, 120);
        ok = find_ev(EV_AR, 5, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0014) begin n_fail++; $display("FAIL fwd_not_taken: got %h expected 30000014", a); end
        mem_ovr.delete();
    endtask

    task automatic test_resp_redirect();
        logic [31:0] a, b;
        bit ok;
        ar_pct = 100; r_delay = 3;
        mem_ovr[RESET_PC] = 32'h0010_0093;
        mem_ovr[32'h3000_0100] = 32'h0020_0113;
        do_reset();
        run_until(EV_AR, 1, 20);
        jump_flush = 1; jump_dnpc = 32'h3000_0100;
        step();
        jump_flush = 0;
        n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL resp_wait_rready: got %b expected 1", rready); end
        run_until(EV_OUT, 1, 60);
        ok = find_ev(EV_AR, 1, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0100) begin n_fail++; $display("FAIL resp_redir_ar: got %h expected 30000100", a); end
        ok = find_ev(EV_OUT, 0, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0100 || b !== 32'h0020_0113) begin n_fail++; $display("FAIL resp_redir_out: got %h/%h expected 30000100/00200113", a, b); end
        mem_ovr.delete();
        r_delay = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        logic [31:0] a, b;
        bit ok;
        w = $urandom;
        w[6:0] = 7'b001_0011;
        mem_ovr[RESET_PC] = w;
        ar_pct = 100; r_delay = 0;
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_out: got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
            n_checks++; if (out_pc !== RESET_PC) begin n_fail++; $display("FAIL bp_pc: got %h expected %h", out_pc, RESET_PC); end
            n_checks++; if (out_inst !== w) begin n_fail++; $display("FAIL bp_inst: got %h expected %h", out_inst, w); end
            n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_arvalid: got %b expected 0", arvalid); end
        end
        out_ready = 1;
        step();
        n_checks++; if (count_ev(EV_OUT) != 1) begin n_fail++; $display("FAIL bp_accept: got %0d expected 1", count_ev(EV_OUT)); end
        run_until(EV_AR, 2, 20);
        ok = find_ev(EV_AR, 1, a, b);
        n_checks++; if (!ok || a !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL bp_next_ar: got %h expected %h", a, RESET_PC + 32'd4); end
        mem_ovr.delete();
    endtask

    task automatic test_dual_flush();
        logic [31:0] a, b;
        bit ok;
        ar_pct = 100; r_delay = 0;
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
        flush = 1; flush_dnpc = 32'h3000_0200;
        jump_flush = 1; jump_dnpc = 32'h3000_0300;
        out_ready = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dual_suppress: got %b expected 0", out_valid); end
        step();
        flush = 0; jump_flush = 0;
        run_until(EV_AR, 2, 30);
        ok = find_ev(EV_AR, 1, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0200) begin n_fail++; $display("FAIL dual_target: got %h expected 30000200", a); end
        n_checks++; if (count_ev(EV_OUT) != 0) begin n_fail++; $display("FAIL dual_no_out: got %0d expected 0", count_ev(EV_OUT)); end
    endtask

    task automatic test_odd_target_reset();
        logic [31:0] a, b;
        bit ok;
        ar_pct = 0; r_delay = 4;
        do_reset();
        step();
        step();
        jump_flush = 1; jump_dnpc = 32'h3000_0101;
        step();
        jump_flush = 0;
        n_checks++; if (araddr !== 32'h3000_0100 || arvalid !== 1'b1) begin n_fail++; $display("FAIL odd_target: got %h/%b expected 30000100/1", araddr, arvalid); end
        ar_pct = 100;
        run_until(EV_AR, 1, 10);
        ok = find_ev(EV_AR, 0, a, b);
        n_checks++; if (!ok || a !== 32'h3000_0100) begin n_fail++; $display("FAIL odd_target_ar: got %h expected 30000100", a); end
        reset = 1;
        step();
        n_checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got %b/%b expected 0/0", arvalid, rready); end
        reset = 0;
        evq.delete();
        run_until(EV_AR, 1, 10);
        ok = find_ev(EV_AR, 0, a, b);
        n_checks++; if (!ok || a !== RESET_PC) begin n_fail++; $display("FAIL refetch: got %h expected %h", a, RESET_PC); end
        r_delay = 0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int r;
        int n_out = 0;
        ar_pct = 60; r_delay = -1; mem_rand = 1;
        mem_ovr.delete();
        do_reset();
        rand_ready = 1;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(99);
            flush      = (r < 3);
            jump_flush = (r >= 3 && r < 7);
            flush_dnpc = RESET_PC + $urandom_range(1023);
            jump_dnpc  = RESET_PC + $urandom_range(1023);
            if (i % 500 == 0) ar_pct = 30 + $urandom_range(70);
            step();
        end
        flush = 0; jump_flush = 0; rand_ready = 0;
        exp_pc = RESET_PC;
        foreach (evq[i]) begin
            if (evq[i].kind == EV_AR && !evq[i].redir) begin
                n_checks++;
                if (evq[i].a !== exp_pc) begin n_fail++; $display("FAIL rand_araddr[%0d]: got %h expected %h", i, evq[i].a, exp_pc); end
            end else if (evq[i].kind == EV_OUT) begin
                n_out++;
                n_checks++;
                if (evq[i].redir || evq[i].a !== exp_pc || evq[i].b !== mem(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d]: got %h/%h redir=%b expected %h/%h", i, evq[i].a, evq[i].b, evq[i].redir, exp_pc, mem(exp_pc));
                end
                exp_pc = predict(exp_pc, mem(exp_pc));
            end else if (evq[i].kind == EV_REDIR) begin
                exp_pc = evq[i].a - (evq[i].a & 32'd1);
            end
        end
        n_checks++; if (n_out < 50) begin n_fail++; $display("FAIL rand_progress: got %0d outputs expected at least 50", n_out); end
        mem_rand = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch_predict();
        test_resp_redirect();
        test_backpressure();
        test_dual_flush();
        test_odd_target_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
